// File: rtl/arbiter_iwrr_pkg.sv
// Shared helpers for the IWRR arbiter and its grant mux: one-hot decode and ID width.
// Pure functions and constants only; no latency or backpressure of its own.
// The ID width helper exists so arbiter and mux always agree on m_id_o sizing.
package arbiter_iwrr_pkg;

    localparam int ONEHOT_W = 32;

    // Requester ID width, never below one bit so a single-requester build still has a port.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic is_onehot(input logic [ONEHOT_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

    function automatic int onehot_to_idx(input logic [ONEHOT_W-1:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < ONEHOT_W; i++) begin
            if (vec[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/arbiter_iwrr_fifo2.sv
// Generic 2-entry in-order FIFO with registered count and full/empty flags.
// Head visible the cycle after a push into an empty FIFO; push/pop allowed together.
// Push while full and pop while empty are ignored; callers gate with full/empty.
module arbiter_iwrr_fifo2 #(
    parameter int P_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           push_i,
    input  logic [P_W-1:0] push_dat_i,
    input  logic           pop_i,
    output logic [P_W-1:0] head_dat_o,
    output logic           full_o,
    output logic           empty_o,
    output logic [1:0]     count_o
);

    logic [P_W-1:0] mem_q [2];
    logic [P_W-1:0] mem_d [2];
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic [1:0]     count_q, count_d;
    logic           push_en, pop_en;

    always_comb begin
        push_en  = push_i && (count_q != 2'd2);
        pop_en   = pop_i && (count_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_en) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == 2'd2);
    assign empty_o    = (count_q == 2'd0);
    assign count_o    = count_q;

endmodule

// File: rtl/arbiter_iwrr_grant_mux.sv
// Turns one-hot arbiter grants into source pops and buffered {id, data} words.
// One cycle from accepted grant to m_valid_o when the 2-entry buffer is empty.
// grant_ready_o drops when the buffer is full, from registered occupancy only.
module arbiter_iwrr_grant_mux
    import arbiter_iwrr_pkg::*;
#(
    parameter int P_REQUESTER_NUM = 3,
    parameter int P_DATA_W        = 32,
    parameter int P_ID_W          = id_width(P_REQUESTER_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [P_REQUESTER_NUM-1:0]          grant_valid_i,
    output logic                                grant_ready_o,
    input  logic [P_REQUESTER_NUM-1:0]          src_valid_i,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0] src_data_i,
    output logic [P_REQUESTER_NUM-1:0]          src_pop_o,
    output logic                                m_valid_o,
    input  logic                                m_ready_i,
    output logic [P_DATA_W-1:0]                 m_data_o,
    output logic [P_ID_W-1:0]                   m_id_o,
    output logic                                err_o
);

    typedef struct packed {
        logic [P_ID_W-1:0]   id;
        logic [P_DATA_W-1:0] dat;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    logic                accept, legal;
    logic [P_DATA_W-1:0] sel_dat;
    entry_t              push_ent, head_ent;
    logic                fifo_full, fifo_empty;
    logic [1:0]          fifo_count;
    logic                err_q, err_d;

    assign grant_ready_o = !fifo_full && !rst;
    assign accept        = grant_ready_o && (grant_valid_i != '0);

    // Legal only when exactly one requester is granted and its queue head is real.
    assign legal = accept
                && is_onehot(ONEHOT_W'(grant_valid_i))
                && ((grant_valid_i & src_valid_i) != '0);

    always_comb begin
        sel_dat = '0;
        for (int k = 0; k < P_REQUESTER_NUM; k++) begin
            if (grant_valid_i[k]) sel_dat = sel_dat | src_data_i[k*P_DATA_W +: P_DATA_W];
        end
    end

    always_comb begin
        push_ent.id  = P_ID_W'(onehot_to_idx(ONEHOT_W'(grant_valid_i)));
        push_ent.dat = sel_dat;
        src_pop_o    = legal ? grant_valid_i : '0;
        err_d        = err_q || (accept && !legal);
    end

    arbiter_iwrr_fifo2 #(
        .P_W (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (legal),
        .push_dat_i (push_ent),
        .pop_i      (m_valid_o && m_ready_i),
        .head_dat_o (head_ent),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign m_valid_o = !fifo_empty;
    assign m_data_o  = head_ent.dat;
    assign m_id_o    = head_ent.id;
    assign err_o     = err_q;

endmodule

// File: tb/tb_arbiter_iwrr_grant_mux.sv
module tb_arbiter_iwrr_grant_mux;

    localparam int N = 3;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   grant;
    logic           grant_rdy;
    logic [N-1:0]   srcv;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   pop;
    logic           m_vld;
    logic           m_rdy;
    logic [W-1:0]   m_dat;
    logic [1:0]     m_id;
    logic           err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbiter_iwrr_grant_mux #(
        .P_REQUESTER_NUM (N),
        .P_DATA_W        (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .grant_valid_i (grant),
        .grant_ready_o (grant_rdy),
        .src_valid_i   (srcv),
        .src_data_i    (src_data),
        .src_pop_o     (pop),
        .m_valid_o     (m_vld),
        .m_ready_i     (m_rdy),
        .m_data_o      (m_dat),
        .m_id_o        (m_id),
        .err_o         (err)
    );

    // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
    task automatic drv(input logic [N-1:0] g, input logic [N-1:0] v, input logic r);
        @(negedge clk);
        grant = g;
        srcv  = v;
        m_rdy = r;
        #1;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_words(input logic [W-1:0] w0, input logic [W-1:0] w1, input logic [W-1:0] w2);
        src_data[0*W +: W] = w0;
        src_data[1*W +: W] = w1;
        src_data[2*W +: W] = w2;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) edge1();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        grant = 3'b001; srcv = 3'b111; m_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            if (m_vld !== 1'b0)   begin errors++; $display("FAIL rst_m_valid: got %b need 0", m_vld); end
            if (m_dat !== 32'h0)  begin errors++; $display("FAIL rst_m_data: got %h need 0", m_dat); end
            if (m_id !== 2'd0)    begin errors++; $display("FAIL rst_m_id: got %0d need 0", m_id); end
            if (err !== 1'b0)     begin errors++; $display("FAIL rst_err: got %b need 0", err); end
            if (grant_rdy !== 1'b0) begin errors++; $display("FAIL rst_grant_ready: got %b need 0", grant_rdy); end
            if (pop !== 3'b000)   begin errors++; $display("FAIL rst_pop: got %b need 000", pop); end
            checks += 6;
        end
        @(negedge clk);
        rst = 1'b0; grant = '0;
        #1;
        if (grant_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b need 1", grant_rdy); end
        checks++;
    endtask

    task automatic test_single_grant();
        set_words(32'h1111_0000, 32'hA5A5_0001, 32'h2222_0002);
        drv(3'b010, 3'b111, 1'b1);
        if (pop !== 3'b010) begin errors++; $display("FAIL single_pop: got %b need 010", pop); end
        checks++;
        edge1();
        if (m_vld !== 1'b1)         begin errors++; $display("FAIL single_valid: got %b need 1", m_vld); end
        if (m_id !== 2'd1)          begin errors++; $display("FAIL single_id: got %0d need 1", m_id); end
        if (m_dat !== 32'hA5A5_0001) begin errors++; $display("FAIL single_data: got %h need a5a50001", m_dat); end
        checks += 3;
        drv(3'b000, 3'b111, 1'b1);
        if (pop !== 3'b000) begin errors++; $display("FAIL single_idle_pop: got %b need 000", pop); end
        checks++;
        edge1();
        if (m_vld !== 1'b0) begin errors++; $display("FAIL single_drain: got %b need 0", m_vld); end
        checks++;
    endtask

    task automatic test_backpressure();
        set_words(32'hB000_0000, 32'hB000_0001, 32'hB000_0002);
        drv(3'b001, 3'b111, 1'b0);
        if (pop !== 3'b001) begin errors++; $display("FAIL bp_pop0: got %b need 001", pop); end
        checks++;
        edge1();
        drv(3'b100, 3'b111, 1'b0);
        if (grant_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b need 1", grant_rdy); end
        if (pop !== 3'b100)     begin errors++; $display("FAIL bp_pop2: got %b need 100", pop); end
        checks += 2;
        edge1();
        drv(3'b010, 3'b111, 1'b0);
        if (grant_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b need 0", grant_rdy); end
        if (pop !== 3'b000)     begin errors++; $display("FAIL bp_full_pop: got %b need 000", pop); end
        if (m_id !== 2'd0 || m_dat !== 32'hB000_0000) begin
            errors++; $display("FAIL bp_hold: got id %0d data %h need id 0 data b0000000", m_id, m_dat);
        end
        checks += 3;
        edge1();
        drv(3'b000, 3'b111, 1'b1);
        if (grant_rdy !== 1'b0) begin errors++; $display("FAIL bp_pop_same_cycle_ready: got %b need 0", grant_rdy); end
        if (m_vld !== 1'b1 || m_id !== 2'd0 || m_dat !== 32'hB000_0000) begin
            errors++; $display("FAIL bp_first_out: got v%b id %0d data %h need v1 id 0 data b0000000", m_vld, m_id, m_dat);
        end
        checks += 2;
        edge1();
        if (grant_rdy !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b need 1", grant_rdy); end
        if (m_vld !== 1'b1 || m_id !== 2'd2 || m_dat !== 32'hB000_0002) begin
            errors++; $display("FAIL bp_second_out: got v%b id %0d data %h need v1 id 2 data b0000002", m_vld, m_id, m_dat);
        end
        checks += 2;
        edge1();
        if (m_vld !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b need 0", m_vld); end
        if (err !== 1'b0)   begin errors++; $display("FAIL bp_no_err: got %b need 0", err); end
        checks += 2;
    endtask

    task automatic test_streaming();
        // Interleaved WRR order for weights {5,3,2}.
        int seq [10] = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 0};
        int cnt [3]  = '{0, 0, 0};
        logic [N-1:0] g;
        for (int i = 0; i <= 10; i++) begin
            set_words(32'hC000_0000 | (i << 8), 32'hC000_0001 | (i << 8), 32'hC000_0002 | (i << 8));
            g = (i < 10) ? N'(1 << seq[i]) : '0;
            drv(g, 3'b111, 1'b1);
            if (i < 10) begin
                if (grant_rdy !== 1'b1 || pop !== g) begin
                    errors++; $display("FAIL stream_accept[%0d]: got rdy %b pop %b need rdy 1 pop %b", i, grant_rdy, pop, g);
                end
                checks++;
            end
            edge1();
            if (i < 10) begin
                if (m_vld !== 1'b1 || m_id !== 2'(seq[i]) || m_dat !== (32'hC000_0000 | (i << 8) | seq[i])) begin
                    errors++; $display("FAIL stream_out[%0d]: got v%b id %0d data %h need v1 id %0d", i, m_vld, m_id, m_dat, seq[i]);
                end
                checks++;
                if (m_vld === 1'b1 && m_id < 2'd3) cnt[m_id]++;
            end else begin
                if (m_vld !== 1'b0) begin errors++; $display("FAIL stream_drain: got %b need 0", m_vld); end
                checks++;
            end
        end
        if (cnt[0] != 5 || cnt[1] != 3 || cnt[2] != 2) begin
            errors++; $display("FAIL stream_weights: got %0d/%0d/%0d need 5/3/2", cnt[0], cnt[1], cnt[2]);
        end
        checks++;
    endtask

    task automatic test_errors();
        do_reset(1);
        drv(3'b011, 3'b111, 1'b1);
        if (pop !== 3'b000) begin errors++; $display("FAIL err_multi_pop: got %b need 000", pop); end
        checks++;
        edge1();
        if (err !== 1'b1 || m_vld !== 1'b0) begin
            errors++; $display("FAIL err_multi: got err %b valid %b need err 1 valid 0", err, m_vld);
        end
        checks++;
        drv(3'b000, 3'b111, 1'b1);
        edge1();
        edge1();
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b need 1", err); end
        checks++;
        do_reset(1);
        if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b need 0", err); end
        checks++;
        drv(3'b100, 3'b011, 1'b1);
        if (pop !== 3'b000) begin errors++; $display("FAIL err_src_pop: got %b need 000", pop); end
        checks++;
        edge1();
        if (err !== 1'b1 || m_vld !== 1'b0) begin
            errors++; $display("FAIL err_src: got err %b valid %b need err 1 valid 0", err, m_vld);
        end
        checks++;
        set_words(32'hD000_0000, 32'hD000_0001, 32'hD000_0002);
        drv(3'b001, 3'b111, 1'b1);
        edge1();
        if (err !== 1'b1 || m_vld !== 1'b1 || m_dat !== 32'hD000_0000) begin
            errors++; $display("FAIL err_then_legal: got err %b v%b data %h need err 1 v1 data d0000000", err, m_vld, m_dat);
        end
        checks++;
        drv(3'b000, 3'b111, 1'b1);
        edge1();
    endtask

    task automatic test_reset_mid();
        set_words(32'hE000_0000, 32'hE000_0001, 32'hE000_0002);
        drv(3'b010, 3'b111, 1'b0);
        edge1();
        drv(3'b001, 3'b111, 1'b0);
        edge1();
        drv(3'b000, 3'b111, 1'b0);
        if (grant_rdy !== 1'b0) begin errors++; $display("FAIL mid_full: got %b need 0", grant_rdy); end
        checks++;
        rst = 1'b1;
        #1;
        if (pop !== 3'b000) begin errors++; $display("FAIL mid_rst_pop: got %b need 000", pop); end
        checks++;
        edge1();
        if (m_vld !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL mid_rst_state: got valid %b err %b need 0 0", m_vld, err);
        end
        checks++;
        @(negedge clk);
        rst = 1'b0; m_rdy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (m_vld !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got valid %b need 0", i, m_vld); end
            checks++;
            edge1();
        end
    endtask

    initial begin
        rst = 1'b1; grant = '0; srcv = '0; m_rdy = 1'b0; src_data = '0;
        test_reset();
        test_single_grant();
        test_backpressure();
        test_streaming();
        test_errors();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
